// File: rtl/sw_ctrl_unit.sv
// ============================================================================
//  Module   : sw_ctrl_unit
//  Purpose  : Stopwatch control FSM (STOP/RUN/CLEAR) with wrap-around preset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_ctrl_unit #(
    parameter int PRESET_MAX = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run_stop,
    input  logic       i_clear,
    input  logic       i_up,
    input  logic       i_down,
    output logic       o_run,
    output logic       o_clear,
    output logic [6:0] o_preset,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_e;

    localparam logic [6:0] c_PRESET_MAX = 7'(PRESET_MAX);

    state_e     state_q, state_d;
    logic       run_q, clear_q;
    logic [6:0] preset_q, preset_d;

    always_comb begin
        state_d = ST_STOP;
        case (state_q)
            ST_STOP: begin
                if (i_clear)
                    state_d = ST_CLEAR;
                else if (i_run_stop)
                    state_d = ST_RUN;
                else
                    state_d = ST_STOP;
            end
            ST_RUN:   state_d = i_run_stop ? ST_STOP : ST_RUN;
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    // Up/down is judged against the current STOP state; entering CLEAR wins.
    always_comb begin
        preset_d = preset_q;
        if (preset_q > c_PRESET_MAX) begin
            preset_d = 7'd0;
        end else if (state_q == ST_STOP) begin
            if (i_up && !i_down)
                preset_d = (preset_q == c_PRESET_MAX) ? 7'd0 : preset_q + 7'd1;
            else if (i_down && !i_up)
                preset_d = (preset_q == 7'd0) ? c_PRESET_MAX : preset_q - 7'd1;
        end
        if (state_d == ST_CLEAR)
            preset_d = 7'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_STOP;
            run_q    <= 1'b0;
            clear_q  <= 1'b0;
            preset_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            run_q    <= (state_d == ST_RUN);
            clear_q  <= (state_d == ST_CLEAR);
            preset_q <= preset_d;
        end
    end

    assign o_run    = run_q;
    assign o_clear  = clear_q;
    assign o_state  = state_q;
    assign o_preset = preset_q;

endmodule

`default_nettype wire
